writeback_ctrl: RTL and testbench

WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

---
 rtl/writeback_ctrl_pkg.sv | 19 +
 rtl/writeback_ctrl.sv | 117 +++++++++++
 tb/tb_writeback_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_ctrl_pkg.sv
// Shared CPU definitions for the writeback controller: state encodings,
// timeout default and the hard-wired zero register address.
package writeback_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_e;

    localparam int         TIMEOUT_CYC_DEFAULT = 15;
    localparam logic [4:0] REG_ZERO            = 5'd0;

    // Smallest counter that can hold TIMEOUT_CYC-1 without wrapping.
    function automatic int cnt_width(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/writeback_ctrl.sv
// Writeback stage controller: writes ALU results directly, fetches load
// data from memory with a bounded wait, and drives the register-file port.
module writeback_ctrl
    import writeback_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] alu_result,
    input  logic [4:0]  rd_addr,
    input  logic        RegWrite,
    input  logic        MemToReg,
    output logic        mem_req,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        err_timeout
);

    localparam int               CNT_W    = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    wb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             mem_req_q, mem_req_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic             err_q, err_d;
    logic             accept;

    // Ready is held low for the whole reset cycle, not just after the edge.
    assign wb_ready    = ready_q & ~rst;
    assign accept      = wb_valid & wb_ready;
    assign mem_req     = mem_req_q;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign err_timeout = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            mem_req_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            mem_req_q  <= mem_req_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_req_d  = 1'b0;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept && RegWrite) begin
                    rf_waddr_d = rd_addr;
                    if (MemToReg) begin
                        state_d   = ST_WAIT_MEM;
                        mem_req_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        state_d    = ST_WRITE;
                        rf_wdata_d = alu_result;
                        rf_we_d    = (rd_addr != REG_ZERO);
                    end
                end
            end
            ST_WAIT_MEM: begin
                // Returning data takes priority over a timeout on the same edge.
                if (mem_rvalid) begin
                    state_d    = ST_WRITE;
                    rf_wdata_d = mem_rdata;
                    rf_we_d    = (rf_waddr_q != REG_ZERO);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

endmodule

// File: tb/tb_writeback_ctrl.sv
// Transaction-level bench for writeback_ctrl with randomized traffic.
module tb_writeback_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] alu_result;
    logic [4:0]  rd_addr;
    logic        RegWrite;
    logic        MemToReg;
    logic        mem_req;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        err_timeout;

    int n_vec = 0;
    int n_err = 0;
    logic pending_err = 1'b0;

    writeback_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .alu_result (alu_result),
        .rd_addr    (rd_addr),
        .RegWrite   (RegWrite),
        .MemToReg   (MemToReg),
        .mem_req    (mem_req),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic junk_req();
        wb_valid   = 1'($urandom_range(0, 1));
        RegWrite   = 1'($urandom_range(0, 1));
        MemToReg   = 1'($urandom_range(0, 1));
        rd_addr    = 5'($urandom);
        alu_result = $urandom;
    endtask

    // kind: 0 = no register write (or no request), 1 = ALU write,
    // 2 = load answered at cycle lat, 3 = load that never gets data.
    task automatic txn(input int kind, input logic [4:0] rd, input logic [31:0] val, input int lat);
        int   busy;
        logic exp_we;
        busy = (kind == 0) ? 0 : (kind == 1) ? 1 : (kind == 2) ? lat + 1 : TO;

        @(posedge clk); #1;
        rst        = 1'b0;
        wb_valid   = (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        RegWrite   = (kind != 0);
        MemToReg   = (kind == 0) ? 1'($urandom_range(0, 1)) : (kind >= 2);
        rd_addr    = rd;
        alu_result = (kind == 1) ? val : $urandom;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        @(negedge clk);
        chk("ready_idle", 32'(wb_ready), 32'(1));
        chk("err_idle", 32'(err_timeout), 32'(pending_err));
        chk("we_idle", 32'(rf_we), 32'(0));
        chk("req_idle", 32'(mem_req), 32'(0));
        pending_err = 1'b0;

        for (int c = 1; c <= busy; c++) begin
            @(posedge clk); #1;
            junk_req();
            if (kind == 2 && c == lat) begin
                mem_rvalid = 1'b1;
                mem_rdata  = val;
            end else if (c == busy && kind != 3) begin
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
            @(negedge clk);
            exp_we = (c == busy) && (kind == 1 || kind == 2) && (rd != 5'd0);
            chk("ready_busy", 32'(wb_ready), 32'(0));
            chk("mem_req", 32'(mem_req), 32'(kind >= 2 && c == 1));
            chk("rf_we", 32'(rf_we), 32'(exp_we));
            chk("err_busy", 32'(err_timeout), 32'(0));
            if (exp_we) begin
                chk("rf_waddr", 32'(rf_waddr), 32'(rd));
                chk("rf_wdata", rf_wdata, val);
            end
        end
        if (kind == 3) pending_err = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(wb_ready), 32'(0));
        chk({tag, "_we"}, 32'(rf_we), 32'(0));
        chk({tag, "_req"}, 32'(mem_req), 32'(0));
        chk({tag, "_err"}, 32'(err_timeout), 32'(0));
        chk({tag, "_waddr"}, 32'(rf_waddr), 32'(0));
        chk({tag, "_wdata"}, rf_wdata, 32'(0));
    endtask

    // Load accepted, reset during its second cycle, stray data afterwards.
    task automatic rst_in_wait(input logic [4:0] rd);
        @(posedge clk); #1;
        rst = 1'b0; wb_valid = 1'b1; RegWrite = 1'b1; MemToReg = 1'b1;
        rd_addr = rd; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("rw_ready0", 32'(wb_ready), 32'(1));
        pending_err = 1'b0;

        @(posedge clk); #1;
        wb_valid = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("rw_req1", 32'(mem_req), 32'(1));

        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rw_ready2", 32'(wb_ready), 32'(0));
        chk("rw_we2", 32'(rf_we), 32'(0));

        @(posedge clk); #1;
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        chk("rw_ready3", 32'(wb_ready), 32'(1));
        chk("rw_we3", 32'(rf_we), 32'(0));
        chk("rw_err3", 32'(err_timeout), 32'(0));
        chk("rw_wdata3", rf_wdata, 32'(0));

        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("rw_we4", 32'(rf_we), 32'(0));
        chk("rw_err4", 32'(err_timeout), 32'(0));
    endtask

    initial begin
        int r;
        rst = 1'b1; wb_valid = 1'b0; RegWrite = 1'b0; MemToReg = 1'b0;
        rd_addr = '0; alu_result = '0; mem_rdata = '0; mem_rvalid = 1'b0;

        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ready_first", 32'(wb_ready), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_state("rst");

        txn(1, 5'd5, 32'h0000_00AB, 0);
        txn(2, 5'd7, 32'hDEAD_BEEF, 3);
        txn(3, 5'd9, $urandom, 0);
        txn(1, 5'd0, 32'h1234_5678, 0);
        txn(0, 5'd4, 32'h0, 0);
        rst_in_wait(5'd12);
        txn(2, 5'd3, 32'hCAFE_F00D, TO);
        txn(2, 5'd0, 32'h5555_AAAA, 1);
        txn(1, 5'd1, $urandom, 0);
        txn(1, 5'd2, $urandom, 0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 10);
            if (r <= 1)      txn(0, 5'($urandom), 32'h0, 0);
            else if (r <= 4) txn(1, 5'($urandom), $urandom, 0);
            else if (r <= 8) txn(2, 5'($urandom), $urandom, $urandom_range(1, TO));
            else if (r == 9) txn(3, 5'($urandom), 32'h0, 0);
            else             rst_in_wait(5'($urandom_range(1, 31)));
        end
        txn(0, 5'd0, 32'h0, 0);
        txn(0, 5'd0, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
